// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V core pipeline: writeback result selects,
// load funct3 codes and the retired-instruction counter width.
package riscv_pkg;

    typedef enum logic [1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10,
        RES_IMM  = 2'b11
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Width of the retired-instruction counter (only built with WB_INSTRET_EN).
    localparam int INSTRET_W = 64;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM/WB boundary bundle: M-stage results and pipeline control in, register
// file write port and WB status out. The stage itself uses the slave side.
interface mem_wb_stage_if;
    logic        stall_w;
    logic        flush_w;
    logic        valid_m;
    logic        reg_write_m;
    logic [1:0]  result_src_m;
    logic [2:0]  funct3_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_result_m;
    logic [31:0] read_data_m;
    logic [31:0] pc_plus4_m;
    logic [31:0] imm_ext_m;

    logic        valid_w;
    logic        reg_write_w;
    logic [4:0]  rd_w;
    logic [31:0] result_w;
    logic        misaligned_w;

    modport master (
        output stall_w, flush_w, valid_m, reg_write_m, result_src_m, funct3_m,
               rd_m, alu_result_m, read_data_m, pc_plus4_m, imm_ext_m,
        input  valid_w, reg_write_w, rd_w, result_w, misaligned_w
    );

    modport slave (
        input  stall_w, flush_w, valid_m, reg_write_m, result_src_m, funct3_m,
               rd_m, alu_result_m, read_data_m, pc_plus4_m, imm_ext_m,
        output valid_w, reg_write_w, rd_w, result_w, misaligned_w
    );
endinterface

// File: rtl/mem_wb_stage_load_extend.sv
// load_extend: picks the addressed byte/halfword out of an aligned memory word,
// sign- or zero-extends it, and flags offsets the access size cannot use.
// Unlisted funct3 codes behave as lw.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_value,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension per load type.
    always_comb begin
        w_byte       = 8'h00;
        w_half       = 16'h0000;
        o_value      = i_word;
        o_misaligned = 1'b0;

        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];

        case (i_funct3)
            F3_LB: begin
                o_value = {{24{w_byte[7]}}, w_byte};
            end
            F3_LBU: begin
                o_value = {24'h000000, w_byte};
            end
            F3_LH: begin
                o_value      = {{16{w_half[15]}}, w_half};
                o_misaligned = i_offset[0];
            end
            F3_LHU: begin
                o_value      = {16'h0000, w_half};
                o_misaligned = i_offset[0];
            end
            default: begin
                o_value      = i_word;
                o_misaligned = |i_offset;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback select. The writeback
// value is resolved at capture time so every output comes straight off a flop.
// Optional feature macro: WB_INSTRET_EN adds the retired-instruction counter
// and its instret output port.
module mem_wb_stage
    import riscv_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    mem_wb_stage_if.slave    bus
`ifdef WB_INSTRET_EN
    ,
    output logic [INSTRET_W-1:0] instret
`endif
);

    logic [31:0] w_load_value;
    logic        w_load_mis;
    logic        w_is_load;
    logic        w_misaligned;
    logic [31:0] w_sel_value;
    logic        w_capture;

    logic        r_valid_w;
    logic        r_reg_write_w;
    logic [4:0]  r_rd_w;
    logic [31:0] r_result_w;
    logic        r_misaligned_w;

    load_extend u_load_extend (
        .i_word       (bus.read_data_m),
        .i_offset     (bus.alu_result_m[1:0]),
        .i_funct3     (bus.funct3_m),
        .o_value      (w_load_value),
        .o_misaligned (w_load_mis)
    );

    assign w_is_load    = (bus.result_src_m == RES_LOAD);
    assign w_misaligned = w_is_load & w_load_mis;
    assign w_capture    = ~bus.flush_w & ~bus.stall_w;

    // Writeback source select.
    always_comb begin
        w_sel_value = bus.alu_result_m;
        case (bus.result_src_m)
            RES_ALU:  w_sel_value = bus.alu_result_m;
            RES_LOAD: w_sel_value = w_load_value;
            RES_PC4:  w_sel_value = bus.pc_plus4_m;
            default:  w_sel_value = bus.imm_ext_m;
        endcase
    end

    // WB register: reset > flush > stall > capture. x0 and misaligned loads
    // never raise the write enable, so forwarding never sees them as writers.
    always_ff @(posedge clk) begin
        if (reset || bus.flush_w) begin
            r_valid_w      <= 1'b0;
            r_reg_write_w  <= 1'b0;
            r_rd_w         <= 5'd0;
            r_result_w     <= 32'h0;
            r_misaligned_w <= 1'b0;
        end else if (!bus.stall_w) begin
            r_valid_w      <= bus.valid_m;
            r_reg_write_w  <= bus.valid_m & bus.reg_write_m & (|bus.rd_m) & ~w_misaligned;
            r_rd_w         <= bus.rd_m;
            r_result_w     <= w_misaligned ? 32'h0 : w_sel_value;
            r_misaligned_w <= w_misaligned;
        end
    end

    assign bus.valid_w      = r_valid_w;
    assign bus.reg_write_w  = r_reg_write_w;
    assign bus.rd_w         = r_rd_w;
    assign bus.result_w     = r_result_w;
    assign bus.misaligned_w = r_misaligned_w;

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] r_instret;

    // Retire count: every real instruction accepted into WB, misaligned loads included.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_capture && bus.valid_m) begin
            r_instret <= r_instret + 1'b1;
        end
    end

    assign instret = r_instret;
`else
    logic w_unused_capture;
    assign w_unused_capture = w_capture;
`endif

endmodule
